// File: rtl/ysyx_22050612_mem_arbiter.sv
// Two-master memory-port arbiter for the NPC core.
// The IFU (read-only) and the LSU (read/write) share one memory port. Only one
// transaction is in flight at a time, and ties are broken round-robin.
// A watchdog turns a memory response that never arrives into an error response.
module ysyx_22050612_mem_arbiter #(
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  // fetch side
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [AW-1:0]   if_addr,
  output logic            if_resp_valid,
  output logic [DW-1:0]   if_rdata,
  output logic            if_resp_err,
  // load/store side
  input  logic            ls_req_valid,
  output logic            ls_req_ready,
  input  logic [AW-1:0]   ls_addr,
  input  logic            ls_wen,
  input  logic [DW-1:0]   ls_wdata,
  input  logic [DW/8-1:0] ls_wmask,
  output logic            ls_resp_valid,
  output logic [DW-1:0]   ls_rdata,
  output logic            ls_resp_err,
  // memory side
  output logic            m_req_valid,
  input  logic            m_req_ready,
  output logic [AW-1:0]   m_addr,
  output logic            m_wen,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wmask,
  input  logic            m_resp_valid,
  input  logic [DW-1:0]   m_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  // Watchdog terminal count. A 16-bit counter covers the full TIMEOUT range.
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic              last_ls;   // 1: the LSU won the most recent grant
  logic              owner_ls;  // 1: the transaction in flight belongs to the LSU
  logic [AW-1:0]     addr_q;
  logic              wen_q;
  logic [DW-1:0]     wdata_q;
  logic [DW/8-1:0]   wmask_q;
  logic [DW-1:0]     rdata_q;
  logic              err_q;
  logic [15:0]       wdog;

  logic              grant_if, grant_ls;
  logic              accept;
  logic              wdog_hit;

  // Grant decode. A lone requester wins. On a tie, the master that lost
  // last time wins.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (state == S_IDLE) begin
      if (if_req_valid && ls_req_valid) begin
        grant_if = last_ls;
        grant_ls = !last_ls;
      end else begin
        grant_if = if_req_valid;
        grant_ls = ls_req_valid;
      end
    end
  end

  // Ready is held low during reset, so nothing can handshake while reset is asserted.
  assign if_req_ready = rst_n & grant_if;
  assign ls_req_ready = rst_n & grant_ls;
  assign accept       = if_req_ready | ls_req_ready;
  assign wdog_hit     = (wdog == WDOG_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt     = state;
    m_req_valid   = 1'b0;
    if_resp_valid = 1'b0;
    ls_resp_valid = 1'b0;
    if_resp_err   = 1'b0;
    ls_resp_err   = 1'b0;
    if_rdata      = '0;
    ls_rdata      = '0;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_ISSUE;
      S_ISSUE: begin
        m_req_valid = 1'b1;
        if (m_req_ready) state_nxt = S_WAIT;
      end
      // A response arriving in the same cycle as the timeout takes priority.
      S_WAIT:  if (m_resp_valid || wdog_hit) state_nxt = S_RESP;
      S_RESP: begin
        state_nxt = S_IDLE;
        if (owner_ls) begin
          ls_resp_valid = 1'b1;
          ls_resp_err   = err_q;
          ls_rdata      = rdata_q;
        end else begin
          if_resp_valid = 1'b1;
          if_resp_err   = err_q;
          if_rdata      = rdata_q;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Latch the request fields and round-robin history at the handshake.
  // A fetch always goes to memory as a read with an empty mask.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      owner_ls <= 1'b0;
      last_ls  <= 1'b1;
    end else if (accept) begin
      owner_ls <= grant_ls;
      last_ls  <= grant_ls;
      if (grant_ls) begin
        addr_q  <= ls_addr;
        wen_q   <= ls_wen;
        wdata_q <= ls_wdata;
        wmask_q <= ls_wmask;
      end else begin
        addr_q  <= if_addr;
        wen_q   <= 1'b0;
        wdata_q <= '0;
        wmask_q <= '0;
      end
    end
  end

  assign m_addr  = addr_q;
  assign m_wen   = wen_q;
  assign m_wdata = wdata_q;
  assign m_wmask = wmask_q;

  // Watchdog. It is cleared when memory accepts the request and counts only
  // while waiting for the response.
  always_ff @(posedge clk) begin
    if (!rst_n)                               wdog <= '0;
    else if (state == S_ISSUE && m_req_ready) wdog <= '0;
    else if (state == S_WAIT)                 wdog <= wdog + 16'd1;
  end

  // Response capture. A store returns zero data, and a timeout returns zero
  // data with the error flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state == S_WAIT) begin
      if (m_resp_valid) begin
        rdata_q <= wen_q ? '0 : m_rdata;
        err_q   <= 1'b0;
      end else if (wdog_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
// Directed bench for the memory arbiter.
// The bench model predicts each transaction's timeline from its accept cycle
// and the scripted memory behaviour. The literal checks pin key cycles.
module tb_ysyx_22050612_mem_arbiter;
  localparam int AW = 64, DW = 64, TO = 8;

  logic          clk = 1'b0, rst_n;
  logic          if_req_valid, if_req_ready, if_resp_valid, if_resp_err;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid, ls_resp_err;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata, ls_rdata;
  logic [7:0]    ls_wmask;
  logic          m_req_valid, m_req_ready, m_wen, m_resp_valid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [7:0]    m_wmask;

  ysyx_22050612_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata), .if_resp_err(if_resp_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata), .ls_resp_err(ls_resp_err),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_addr(m_addr),
    .m_wen(m_wen), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_resp_valid(m_resp_valid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Memory behaviour per transaction: rd = cycles ready is held low in issue,
  // d = index of the wait cycle that carries the response.
  typedef struct { int rd; int d; logic [63:0] data; } cfg_t;
  typedef struct { logic [63:0] addr; logic wen; logic [63:0] wdata; logic [7:0] wmask; } lsreq_t;

  cfg_t          mem_q[$], mdl_q[$];
  logic [63:0]   ifq[$];
  lsreq_t        lsq[$];
  int            glog[$];
  int            vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_cfg(input int rd, input int d, input logic [63:0] data);
    cfg_t c;
    c.rd = rd; c.d = d; c.data = data;
    mem_q.push_back(c);
    mdl_q.push_back(c);
  endtask

  task automatic push_ls(input logic [63:0] a, input logic w, input logic [63:0] wd, input logic [7:0] wm);
    lsreq_t r;
    r.addr = a; r.wen = w; r.wdata = wd; r.wmask = wm;
    lsq.push_back(r);
  endtask

  // Master drivers. Each master holds its request until it is accepted, then
  // presents the next queued request. Accepted grants are logged in order.
  initial begin
    bit hs_if, hs_ls;
    lsreq_t r;
    forever begin
      @(negedge clk);
      hs_if = if_req_valid && if_req_ready;
      hs_ls = ls_req_valid && ls_req_ready;
      @(posedge clk); #2;
      if (hs_if) begin if_req_valid = 1'b0; glog.push_back(0); end
      if (hs_ls) begin ls_req_valid = 1'b0; glog.push_back(1); end
      if (!if_req_valid && ifq.size() > 0) begin
        if_addr = ifq.pop_front(); if_req_valid = 1'b1;
      end
      if (!ls_req_valid && lsq.size() > 0) begin
        r = lsq.pop_front();
        ls_addr = r.addr; ls_wen = r.wen; ls_wdata = r.wdata; ls_wmask = r.wmask;
        ls_req_valid = 1'b1;
      end
    end
  end

  // Scripted memory. It reacts to each issued request and abandons the
  // transaction if reset is asserted.
  initial begin
    cfg_t c;
    bit   abort;
    m_req_ready = 1'b0; m_resp_valid = 1'b0; m_rdata = '0;
    forever begin
      @(negedge clk);
      if (m_req_valid === 1'b1) begin
        if (mem_q.size() > 0) c = mem_q.pop_front();
        else begin c.rd = 0; c.d = 0; c.data = '0; end
        abort = 1'b0;
        repeat (c.rd) @(negedge clk);
        #1 m_req_ready = 1'b1;
        @(posedge clk); #2 m_req_ready = 1'b0;
        if (!rst_n) abort = 1'b1;
        for (int k = 0; k < c.d && !abort; k++) begin
          @(posedge clk); #2;
          if (!rst_n) abort = 1'b1;
        end
        if (!abort) begin
          m_resp_valid = 1'b1; m_rdata = c.data;
          @(posedge clk); #2 m_resp_valid = 1'b0; m_rdata = '0;
        end
      end
    end
  end

  // Timeline model and per-cycle compare.
  initial begin
    int n = 0, acc = -1, iss_end = -1, resp_cyc = -1, busy_end = 0, waitc;
    bit last_ls = 1'b1, own_ls = 1'b0, g_if, g_ls, idle, rv, e_err = 1'b0;
    logic [63:0] e_addr = '0, e_wdata = '0, e_rdata = '0;
    logic e_wen = 1'b0;
    logic [7:0] e_wmask = '0;
    cfg_t c;
    forever begin
      @(negedge clk);
      n++;
      if (!rst_n) begin
        chk("rst_if_ready", 64'(if_req_ready), 64'd0);
        chk("rst_ls_ready", 64'(ls_req_ready), 64'd0);
        acc = -1; iss_end = -1; resp_cyc = -1; busy_end = n; last_ls = 1'b1;
        e_addr = '0; e_wdata = '0; e_wen = 1'b0; e_wmask = '0;
        continue;
      end
      idle = (n > busy_end);
      g_if = idle && if_req_valid && (!ls_req_valid || last_ls);
      g_ls = idle && ls_req_valid && (!if_req_valid || !last_ls);
      chk("if_req_ready", 64'(if_req_ready), 64'(g_if));
      chk("ls_req_ready", 64'(ls_req_ready), 64'(g_ls));
      chk("m_req_valid", 64'(m_req_valid), 64'(n > acc && n <= iss_end));
      chk("m_addr", m_addr, e_addr);
      chk("m_wen", 64'(m_wen), 64'(e_wen));
      chk("m_wdata", m_wdata, e_wdata);
      chk("m_wmask", 64'(m_wmask), 64'(e_wmask));
      rv = (n == resp_cyc);
      chk("if_resp_valid", 64'(if_resp_valid), 64'(rv && !own_ls));
      chk("ls_resp_valid", 64'(ls_resp_valid), 64'(rv && own_ls));
      chk("if_rdata", if_rdata, (rv && !own_ls) ? e_rdata : 64'd0);
      chk("ls_rdata", ls_rdata, (rv && own_ls) ? e_rdata : 64'd0);
      chk("if_resp_err", 64'(if_resp_err), 64'(rv && !own_ls && e_err));
      chk("ls_resp_err", 64'(ls_resp_err), 64'(rv && own_ls && e_err));
      if (g_if || g_ls) begin
        if (mdl_q.size() > 0) c = mdl_q.pop_front();
        else begin c.rd = 0; c.d = 0; c.data = '0; end
        acc = n; own_ls = g_ls; last_ls = g_ls;
        if (g_ls) begin
          e_addr = ls_addr; e_wen = ls_wen; e_wdata = ls_wdata; e_wmask = ls_wmask;
        end else begin
          e_addr = if_addr; e_wen = 1'b0; e_wdata = '0; e_wmask = '0;
        end
        iss_end  = n + c.rd + 1;
        e_err    = (c.d >= TO);
        waitc    = e_err ? TO : c.d + 1;
        resp_cyc = iss_end + waitc + 1;
        busy_end = resp_cyc;
        e_rdata  = (e_err || e_wen) ? 64'd0 : c.data;
      end
    end
  end

  // Directed scenarios with literal checkpoints.
  initial begin
    int gi, g;
    int exp_seq[6] = '{0, 1, 0, 1, 0, 1};
    rst_n = 1'b0;
    if_req_valid = 1'b0; if_addr = '0;
    ls_req_valid = 1'b0; ls_addr = '0; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_m_req_valid", 64'(m_req_valid), 64'd0);
    chk("reset_m_addr", m_addr, 64'd0);
    chk("reset_if_resp_valid", 64'(if_resp_valid), 64'd0);

    // Single IFU read with minimum latency.
    @(posedge clk); #1;
    push_cfg(0, 0, 64'h00000413_00000093);
    ifq.push_back(64'h80000000);
    @(negedge clk);
    chk("t1_accept", 64'(if_req_ready), 64'd1);
    @(negedge clk);
    chk("t1_issue", 64'(m_req_valid), 64'd1);
    chk("t1_addr", m_addr, 64'h80000000);
    chk("t1_wen", 64'(m_wen), 64'd0);
    chk("t1_wmask", 64'(m_wmask), 64'd0);
    repeat (2) @(negedge clk);
    chk("t1_resp", 64'(if_resp_valid), 64'd1);
    chk("t1_rdata", if_rdata, 64'h00000413_00000093);
    chk("t1_err", 64'(if_resp_err), 64'd0);

    // LSU store. Memory stalls the request for 3 cycles.
    @(posedge clk); #1;
    push_cfg(3, 1, 64'h1234);
    push_ls(64'h80001000, 1'b1, 64'hDEADBEEF, 8'h0F);
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t2_hold_valid", 64'(m_req_valid), 64'd1);
      chk("t2_hold_addr", m_addr, 64'h80001000);
      chk("t2_hold_wdata", m_wdata, 64'hDEADBEEF);
      chk("t2_hold_wmask", 64'(m_wmask), 64'h0F);
      chk("t2_hold_wen", 64'(m_wen), 64'd1);
    end
    @(negedge clk);
    chk("t2_issue_done", 64'(m_req_valid), 64'd0);
    repeat (2) @(negedge clk);
    chk("t2_resp", 64'(ls_resp_valid), 64'd1);
    chk("t2_rdata", ls_rdata, 64'd0);

    // Both masters request continuously after reset, so grants alternate.
    @(posedge clk); #1 rst_n = 1'b0;
    glog.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) push_cfg(0, 0, 64'h1000 + 64'(i));
    for (int i = 0; i < 3; i++) begin
      ifq.push_back(64'h80000100 + 64'(i * 4));
      push_ls(64'h80004000 + 64'(i * 8), 1'b0, 64'd0, 8'd0);
    end
    repeat (30) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      g = (i < glog.size()) ? glog[i] : 2;
      chk("t3_grant_order", 64'(g), 64'(exp_seq[i]));
    end

    // Timeout. A late response lands in idle and is ignored, and the IFU read
    // that follows completes normally.
    @(posedge clk); #1;
    push_cfg(0, 9, 64'hBAD);
    push_ls(64'h80002000, 1'b0, 64'd0, 8'd0);
    @(posedge clk); #1;
    push_cfg(0, 0, 64'h600D);
    ifq.push_back(64'h80000040);
    repeat (10) @(negedge clk);
    chk("t4_timeout_resp", 64'(ls_resp_valid), 64'd1);
    chk("t4_timeout_err", 64'(ls_resp_err), 64'd1);
    chk("t4_timeout_rdata", ls_rdata, 64'd0);
    repeat (4) @(negedge clk);
    chk("t4_next_resp", 64'(if_resp_valid), 64'd1);
    chk("t4_next_rdata", if_rdata, 64'h600D);
    chk("t4_next_err", 64'(if_resp_err), 64'd0);

    // Reset during the wait phase of an IFU read.
    @(posedge clk); #1;
    push_cfg(0, 20, 64'h77);
    ifq.push_back(64'h80000080);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t5_if_resp_valid", 64'(if_resp_valid), 64'd0);
    chk("t5_m_req_valid", 64'(m_req_valid), 64'd0);
    chk("t5_m_addr", m_addr, 64'd0);
    chk("t5_if_rdata", if_rdata, 64'd0);
    gi = glog.size();
    @(posedge clk); #1;
    push_cfg(0, 0, 64'hA1);
    push_cfg(0, 0, 64'hA2);
    ifq.push_back(64'h800000C0);
    push_ls(64'h80005000, 1'b0, 64'd0, 8'd0);
    repeat (10) @(negedge clk);
    g = (gi < glog.size()) ? glog[gi] : 2;
    chk("t5_tie_after_reset", 64'(g), 64'd0);

    // A response in the last wait cycle wins over the timeout.
    @(posedge clk); #1;
    push_cfg(1, TO - 1, 64'hCAFE);
    push_ls(64'h80003000, 1'b0, 64'd0, 8'd0);
    repeat (12) @(negedge clk);
    chk("t6_resp", 64'(ls_resp_valid), 64'd1);
    chk("t6_err", 64'(ls_resp_err), 64'd0);
    chk("t6_rdata", ls_rdata, 64'hCAFE);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
